// File: rtl/rob_pkg.sv
// Shared types and sizing helpers for the reorder buffer.
package rob_pkg;
  localparam int PC_W       = 12;
  localparam int AREG_W_MAX = 8;
  localparam int PREG_W_MAX = 10;

  // Payload per entry; valid/done live in flat vectors so the commit scan can index them directly.
  typedef struct packed {
    logic                  reg_write;
    logic [AREG_W_MAX-1:0] areg;
    logic [PREG_W_MAX-1:0] preg;
    logic [PREG_W_MAX-1:0] old_preg;
    logic [PC_W-1:0]       pc;
  } rob_entry_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/rob_commit_logic.sv
// Combinational in-order retire scan: slot k is ready only if entries head..head+k are all valid and done.
// Zero latency from registered valid/done state; no handshake.
module rob_commit_logic #(
  parameter int DEPTH    = 16,
  parameter int COMMIT_W = 2,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 2
) (
  input  logic [IDX_W-1:0]          head_i,
  input  logic [DEPTH-1:0]          valid_i,
  input  logic [DEPTH-1:0]          done_i,
  output logic [COMMIT_W-1:0]       ready_o,
  output logic [COMMIT_W*IDX_W-1:0] slot_idx_o,
  output logic [CNT_W-1:0]          num_o
);
  logic             run;
  logic [IDX_W-1:0] idx;

  always_comb begin
    ready_o    = '0;
    slot_idx_o = '0;
    num_o      = '0;
    run        = 1'b1;
    idx        = head_i;
    for (int k = 0; k < COMMIT_W; k++) begin
      idx = head_i + IDX_W'(k);
      run = run & valid_i[idx] & done_i[idx];
      ready_o[k] = run;
      slot_idx_o[k*IDX_W +: IDX_W] = idx;
      if (run) num_o = num_o + CNT_W'(1);
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order-retire ROB: alloc returns tail tag, CDB marks done, up to COMMIT_W retire per cycle.
// Completion visible to commit one cycle later; alloc_ready is the registered !full, so freed slots reuse next cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  parameter int NUM_CDB    = 3,
  parameter int COMMIT_W   = 2,
  parameter int IDX_W      = idx_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic                           alloc_reg_write,
  input  logic [AREG_WIDTH-1:0]          alloc_areg,
  input  logic [PREG_WIDTH-1:0]          alloc_preg,
  input  logic [PREG_WIDTH-1:0]          alloc_old_preg,
  input  logic [PC_W-1:0]                alloc_pc,
  output logic [IDX_W-1:0]               alloc_tag,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*IDX_W-1:0]       cdb_tag,
  input  logic                           flush,
  output logic [COMMIT_W-1:0]            commit_valid,
  output logic [COMMIT_W*AREG_WIDTH-1:0] commit_areg,
  output logic [COMMIT_W*PREG_WIDTH-1:0] commit_preg,
  output logic [COMMIT_W-1:0]            free_push,
  output logic [COMMIT_W*PREG_WIDTH-1:0] free_reg,
  output logic [IDX_W:0]                 count,
  output logic                           empty,
  output logic                           full
);
  localparam int CNT_W = $clog2(COMMIT_W + 1);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  rob_entry_t       ent_q [DEPTH];

  logic [COMMIT_W-1:0]       ready;
  logic [COMMIT_W*IDX_W-1:0] slot_idx;
  logic [CNT_W-1:0]          num_commit;
  logic                      alloc_fire;
  logic [IDX_W-1:0]          tail_idx;
  logic [IDX_W-1:0]          slot;
  logic [IDX_W-1:0]          ctag;
  rob_entry_t                ent;

  assign tail_idx    = tail_q[IDX_W-1:0];
  assign full        = (tail_idx == head_q[IDX_W-1:0]) && (tail_q[IDX_W] != head_q[IDX_W]);
  assign empty       = (tail_q == head_q);
  assign count       = tail_q - head_q;
  assign alloc_ready = ~full;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid & ~full & ~flush;

  rob_commit_logic #(
    .DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) u_commit (
    .head_i    (head_q[IDX_W-1:0]),
    .valid_i   (valid_q),
    .done_i    (done_q),
    .ready_o   (ready),
    .slot_idx_o(slot_idx),
    .num_o     (num_commit)
  );

  // Order matters: completions, then retire clears, then the new allocation; flush overrides everything.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q + PTR_W'(num_commit);
    tail_d  = tail_q + PTR_W'(alloc_fire);
    ctag    = '0;
    slot    = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      ctag = cdb_tag[p*IDX_W +: IDX_W];
      if (cdb_valid[p] && valid_q[ctag]) done_d[ctag] = 1'b1;
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      slot = slot_idx[k*IDX_W +: IDX_W];
      if (ready[k]) begin
        valid_d[slot] = 1'b0;
        done_d[slot]  = 1'b0;
      end
    end
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
    end
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      ent_q[tail_idx] <= '{reg_write: alloc_reg_write,
                           areg:      AREG_W_MAX'(alloc_areg),
                           preg:      PREG_W_MAX'(alloc_preg),
                           old_preg:  PREG_W_MAX'(alloc_old_preg),
                           pc:        alloc_pc};
    end
  end

  // Data outputs are zeroed on idle slots so downstream sees clean buses.
  always_comb begin
    commit_valid = ready & {COMMIT_W{~flush}};
    commit_areg  = '0;
    commit_preg  = '0;
    free_push    = '0;
    free_reg     = '0;
    ent          = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      ent = ent_q[slot_idx[k*IDX_W +: IDX_W]];
      if (commit_valid[k]) begin
        commit_areg[k*AREG_WIDTH +: AREG_WIDTH] = ent.areg[AREG_WIDTH-1:0];
        commit_preg[k*PREG_WIDTH +: PREG_WIDTH] = ent.preg[PREG_WIDTH-1:0];
        free_reg[k*PREG_WIDTH +: PREG_WIDTH]    = ent.old_preg[PREG_WIDTH-1:0];
        free_push[k] = ent.reg_write;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer at default parameters (DEPTH=16, NUM_CDB=3, COMMIT_W=2).
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready, alloc_reg_write;
  logic [4:0]  alloc_areg;
  logic [5:0]  alloc_preg, alloc_old_preg;
  logic [11:0] alloc_pc;
  logic [3:0]  alloc_tag;
  logic [2:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic        flush;
  logic [1:0]  commit_valid, free_push;
  logic [9:0]  commit_areg;
  logic [11:0] commit_preg, free_reg;
  logic [4:0]  count;
  logic        empty, full;

  int n_cmp  = 0;
  int n_fail = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_reg_write(alloc_reg_write),
    .alloc_areg(alloc_areg), .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
    .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .flush(flush),
    .commit_valid(commit_valid), .commit_areg(commit_areg), .commit_preg(commit_preg),
    .free_push(free_push), .free_reg(free_reg),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    alloc_valid = 0; alloc_reg_write = 0; alloc_areg = '0; alloc_preg = '0;
    alloc_old_preg = '0; alloc_pc = '0; cdb_valid = '0; cdb_tag = '0; flush = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic do_alloc(input logic rw, input logic [4:0] a, input logic [5:0] p,
                          input logic [5:0] op, input logic [3:0] exp_tag);
    alloc_valid = 1; alloc_reg_write = rw; alloc_areg = a;
    alloc_preg = p; alloc_old_preg = op; alloc_pc = {8'h10, exp_tag};
    #1;
    n_cmp++;
    if (alloc_tag !== exp_tag) begin n_fail++; $display("FAIL alloc_tag: got %0d want %0d", alloc_tag, exp_tag); end
    step();
    alloc_valid = 0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty %0b full %0b want 1 0", empty, full); end
    n_cmp++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin n_fail++; $display("FAIL reset_alloc: ready %0b tag %0d want 1 0", alloc_ready, alloc_tag); end
    n_cmp++; if (commit_valid !== 2'b00 || free_push !== 2'b00 || free_reg !== 12'd0) begin n_fail++; $display("FAIL reset_commit: cv %b fp %b fr %h want 0", commit_valid, free_push, free_reg); end
  endtask

  task automatic test_alloc3;
    do_alloc(1, 5'd5, 6'd32, 6'd1, 4'd0);
    do_alloc(1, 5'd6, 6'd33, 6'd2, 4'd1);
    do_alloc(1, 5'd7, 6'd34, 6'd3, 4'd2);
    n_cmp++; if (count !== 5'd3) begin n_fail++; $display("FAIL alloc3_count: got %0d want 3", count); end
    n_cmp++; if (commit_valid !== 2'b00) begin n_fail++; $display("FAIL alloc3_commit: got %b want 00", commit_valid); end
  endtask

  task automatic test_complete_pair;
    cdb_valid = 3'b011; cdb_tag = {4'd0, 4'd0, 4'd1};
    #1;
    n_cmp++; if (commit_valid !== 2'b00) begin n_fail++; $display("FAIL no_bypass: got %b want 00", commit_valid); end
    step();
    cdb_valid = '0;
    n_cmp++; if (commit_valid !== 2'b11 || free_push !== 2'b11) begin n_fail++; $display("FAIL pair_valid: cv %b fp %b want 11 11", commit_valid, free_push); end
    n_cmp++; if (free_reg !== {6'd2, 6'd1}) begin n_fail++; $display("FAIL pair_free_reg: got %h want %h", free_reg, {6'd2, 6'd1}); end
    n_cmp++; if (commit_preg !== {6'd33, 6'd32} || commit_areg !== {5'd6, 5'd5}) begin n_fail++; $display("FAIL pair_data: preg %h areg %h", commit_preg, commit_areg); end
    step();
    n_cmp++; if (count !== 5'd1 || commit_valid !== 2'b00) begin n_fail++; $display("FAIL pair_after: count %0d cv %b want 1 00", count, commit_valid); end
  endtask

  task automatic test_no_regwrite;
    do_alloc(0, 5'd9, 6'd40, 6'd7, 4'd3);
    cdb_valid = 3'b001; cdb_tag = {8'd0, 4'd2};
    step();
    cdb_valid = '0;
    n_cmp++; if (commit_valid !== 2'b01 || free_push !== 2'b01 || free_reg !== {6'd0, 6'd3}) begin n_fail++; $display("FAIL single_rw: cv %b fp %b fr %h", commit_valid, free_push, free_reg); end
    step();
    cdb_valid = 3'b001; cdb_tag = {8'd0, 4'd3};
    step();
    cdb_valid = '0;
    n_cmp++; if (commit_valid !== 2'b01 || free_push !== 2'b00) begin n_fail++; $display("FAIL no_rw: cv %b fp %b want 01 00", commit_valid, free_push); end
    n_cmp++; if (commit_areg !== {5'd0, 5'd9} || commit_preg !== {6'd0, 6'd40}) begin n_fail++; $display("FAIL no_rw_data: areg %h preg %h", commit_areg, commit_preg); end
    step();
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL no_rw_empty: got %b want 1", empty); end
  endtask

  task automatic test_back_to_back;
    do_alloc(1, 5'd1, 6'd20, 6'd11, 4'd4);
    cdb_valid = 3'b100; cdb_tag = {4'd4, 8'd0};
    step();
    cdb_valid = '0;
    n_cmp++; if (commit_valid !== 2'b01 || free_reg !== {6'd0, 6'd11}) begin n_fail++; $display("FAIL b2b_commit: cv %b fr %h", commit_valid, free_reg); end
    do_alloc(1, 5'd2, 6'd21, 6'd12, 4'd5);
    n_cmp++; if (count !== 5'd1 || commit_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_count: count %0d cv %b want 1 00", count, commit_valid); end
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(1, 5'(i), 6'(i + 16), 6'(i), 4'(i));
    n_cmp++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 5'd16) begin n_fail++; $display("FAIL fill: full %b ready %b count %0d", full, alloc_ready, count); end
    alloc_valid = 1; alloc_preg = 6'd63;
    step();
    alloc_valid = 0;
    n_cmp++; if (count !== 5'd16 || full !== 1'b1 || alloc_tag !== 4'd0) begin n_fail++; $display("FAIL overfill: count %0d full %b tag %0d", count, full, alloc_tag); end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 14; i++) do_alloc(1, 5'(i), 6'(i), 6'(i), 4'(i));
    for (int i = 0; i < 14; i++) begin
      cdb_valid = 3'b001; cdb_tag = {8'd0, 4'(i)};
      step();
    end
    cdb_valid = '0;
    step(); step(); step();
    n_cmp++; if (empty !== 1'b1 || count !== 5'd0 || alloc_tag !== 4'd14) begin n_fail++; $display("FAIL wrap_drain: empty %b count %0d tag %0d", empty, count, alloc_tag); end
    do_alloc(1, 5'd1, 6'd50, 6'd10, 4'd14);
    do_alloc(1, 5'd2, 6'd51, 6'd11, 4'd15);
    do_alloc(1, 5'd3, 6'd52, 6'd12, 4'd0);
    do_alloc(1, 5'd4, 6'd53, 6'd13, 4'd1);
    n_cmp++; if (count !== 5'd4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", count); end
    cdb_valid = 3'b111; cdb_tag = {4'd0, 4'd15, 4'd14};
    step();
    cdb_valid = 3'b001; cdb_tag = {8'd0, 4'd1};
    #1;
    n_cmp++; if (commit_valid !== 2'b11 || commit_preg !== {6'd51, 6'd50} || free_reg !== {6'd11, 6'd10}) begin n_fail++; $display("FAIL wrap_first: cv %b preg %h fr %h", commit_valid, commit_preg, free_reg); end
    step();
    cdb_valid = '0;
    n_cmp++; if (commit_valid !== 2'b11 || commit_preg !== {6'd53, 6'd52} || free_reg !== {6'd13, 6'd12}) begin n_fail++; $display("FAIL wrap_second: cv %b preg %h fr %h", commit_valid, commit_preg, free_reg); end
    step();
    n_cmp++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL wrap_empty: empty %b count %0d", empty, count); end
  endtask

  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 5; i++) do_alloc(1, 5'(i), 6'(i + 8), 6'(i), 4'(i));
    cdb_valid = 3'b001; cdb_tag = {8'd0, 4'd0};
    step();
    n_cmp++; if (commit_valid !== 2'b01) begin n_fail++; $display("FAIL preflush: cv %b want 01", commit_valid); end
    flush = 1; cdb_tag = {8'd0, 4'd1}; alloc_valid = 1;
    #1;
    n_cmp++; if (commit_valid !== 2'b00 || free_push !== 2'b00) begin n_fail++; $display("FAIL flush_gate: cv %b fp %b want 00 00", commit_valid, free_push); end
    step();
    clear_inputs();
    #1;
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || alloc_tag !== 4'd0 || commit_valid !== 2'b00) begin n_fail++; $display("FAIL flush_after: count %0d empty %b tag %0d cv %b", count, empty, alloc_tag, commit_valid); end
  endtask

  task automatic test_async_rst;
    do_alloc(1, 5'd1, 6'd30, 6'd5, 4'd0);
    do_alloc(1, 5'd2, 6'd31, 6'd6, 4'd1);
    do_alloc(1, 5'd3, 6'd32, 6'd7, 4'd2);
    cdb_valid = 3'b001; cdb_tag = {8'd0, 4'd0};
    step();
    cdb_valid = '0;
    n_cmp++; if (commit_valid !== 2'b01 || count !== 5'd3) begin n_fail++; $display("FAIL prerst: cv %b count %0d", commit_valid, count); end
    #2;
    rst = 1;
    #1;
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || alloc_tag !== 4'd0) begin n_fail++; $display("FAIL async_rst_state: count %0d empty %b tag %0d", count, empty, alloc_tag); end
    n_cmp++; if (commit_valid !== 2'b00 || free_push !== 2'b00 || free_reg !== 12'd0) begin n_fail++; $display("FAIL async_rst_commit: cv %b fp %b fr %h", commit_valid, free_push, free_reg); end
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_alloc3();
    test_complete_pair();
    test_no_regwrite();
    test_back_to_back();
    test_fill();
    test_wrap();
    test_flush();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
